// File: rtl/core_irq_aggregator_if.sv
// rtl/core_irq_aggregator_if.sv - Avalon-MM style register bus for the IRQ aggregator
//
// Signals:
//   address    [2:0]  register select
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata  [15:0] write data
//   readdata   [15:0] registered read data (driven by the slave)
// Modports: master (CPU side), slave (aggregator side).

interface core_irq_aggregator_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/core_irq_aggregator.sv
// rtl/core_irq_aggregator.sv - memory-mapped interrupt aggregator with edge/level sources
//
// Collects NUM_IRQ (1..16) interrupt lines, latches edge-mode sources, masks and
// priority-encodes pending sources and drives one registered irq to the CPU.
//
// Ports:
//   clk      - single clock
//   reset_n  - asynchronous active-low reset
//   bus      - register slave (address/chipselect/write_n/writedata/readdata)
//   irq_in   - peripheral IRQ levels, NUM_IRQ bits
//   irq      - aggregated registered interrupt
//
// Register map: 0 PENDING (W1C, edge bits only), 1 MASK, 2 RAW, 3 MODE (1=edge),
//               4 ACTIVE ({any, 11'b0, lowest index}), 5 CONTROL (bit 0 GIE), 6/7 read 0.
//
// Configuration macro CORE_IRQ_AGGREGATOR_SYNC_EN: when defined, a 2-flop
// synchronizer per bit sits ahead of raw_q (assert latency grows by 2 cycles).

module core_irq_aggregator #(
    parameter int NUM_IRQ = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    core_irq_aggregator_if.slave      bus,
    input  logic [NUM_IRQ-1:0]        irq_in,
    output logic                      irq
);

    // Bits at and above NUM_IRQ are forced to zero in every register.
    localparam logic [15:0] IMPL_MASK = 16'((32'h1 << NUM_IRQ) - 32'h1);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_RAW     = 3'd2;
    localparam logic [2:0] ADDR_MODE    = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
    localparam logic [2:0] ADDR_CONTROL = 3'd5;

    logic [15:0] r_raw_q;
    logic [15:0] r_raw_d;
    logic [15:0] r_pending;
    logic [15:0] r_mask;
    logic [15:0] r_mode;
    logic        r_gie;
    logic [15:0] r_readdata;
    logic        r_irq;

    logic [15:0] w_irq_in;
    logic [15:0] w_sample;
    logic        w_wr;
    logic [15:0] w_edge_clr;
    logic [15:0] w_rise;
    logic [15:0] w_edge_next;
    logic [15:0] w_pending_next;
    logic [15:0] w_active;
    logic        w_any;
    logic [3:0]  w_act_idx;
    logic [15:0] w_rdata;

    assign w_irq_in = 16'(irq_in) & IMPL_MASK;

`ifdef CORE_IRQ_AGGREGATOR_SYNC_EN
    logic [15:0] r_sync1;
    logic [15:0] r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 16'h0000;
            r_sync2 <= 16'h0000;
        end else begin
            r_sync1 <= w_irq_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = w_irq_in;
`endif

    assign w_wr = bus.chipselect & ~bus.write_n;

    // Edge-mode clear sources: W1C on PENDING, or any MODE write (clears all).
    always_comb begin
        w_edge_clr = 16'h0000;
        if (w_wr && (bus.address == ADDR_PENDING)) begin
            w_edge_clr = bus.writedata;
        end
        if (w_wr && (bus.address == ADDR_MODE)) begin
            w_edge_clr = 16'hFFFF;
        end
    end

    // A rising edge in the same cycle as a clear wins, so set is ORed last.
    assign w_rise         = r_raw_q & ~r_raw_d;
    assign w_edge_next    = w_rise | (r_pending & ~w_edge_clr);
    assign w_pending_next = ((r_mode & w_edge_next) | (~r_mode & r_raw_q)) & IMPL_MASK;

    assign w_active = r_pending & r_mask;
    assign w_any    = |w_active;

    // Scan from the top so the lowest set index is the last assignment.
    always_comb begin
        w_act_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_active[i]) begin
                w_act_idx = 4'(i);
            end
        end
    end

    // Read mux is intentionally not qualified by chipselect.
    always_comb begin
        w_rdata = 16'h0000;
        case (bus.address)
            ADDR_PENDING: w_rdata = r_pending;
            ADDR_MASK:    w_rdata = r_mask;
            ADDR_RAW:     w_rdata = r_raw_q;
            ADDR_MODE:    w_rdata = r_mode;
            ADDR_ACTIVE:  w_rdata = {w_any, 11'b0, w_act_idx};
            ADDR_CONTROL: w_rdata = {15'b0, r_gie};
            default:      w_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_raw_q    <= 16'h0000;
            r_raw_d    <= 16'h0000;
            r_pending  <= 16'h0000;
            r_mask     <= 16'h0000;
            r_mode     <= 16'h0000;
            r_gie      <= 1'b0;
            r_readdata <= 16'h0000;
            r_irq      <= 1'b0;
        end else begin
            r_raw_q    <= w_sample;
            r_raw_d    <= r_raw_q;
            r_pending  <= w_pending_next;
            r_readdata <= w_rdata;
            r_irq      <= r_gie & w_any;
            if (w_wr && (bus.address == ADDR_MASK)) begin
                r_mask <= bus.writedata & IMPL_MASK;
            end
            if (w_wr && (bus.address == ADDR_MODE)) begin
                r_mode <= bus.writedata & IMPL_MASK;
            end
            if (w_wr && (bus.address == ADDR_CONTROL)) begin
                r_gie <= bus.writedata[0];
            end
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = r_irq;

endmodule
